// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing 24-bit instruction words into program memory
//
// Receives a length byte followed by opcode/arg_a/arg_b byte triplets over a
// valid/ready byte stream, checks each opcode, and writes one 24-bit word per
// triplet into program memory while holding the CPU core stalled.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : single-cycle pulse that begins a load session
//   byte_valid    : source presents byte_data this cycle
//   byte_data     : stream byte
//   byte_ready    : loader accepts a byte this cycle
//   mem_w_enable  : program-memory write strobe, one cycle per word
//   mem_w_addr    : program-memory write address (0 when not writing)
//   mem_w_data    : {opcode, arg_a, arg_b} (0 when not writing)
//   cpu_hold      : keeps the CPU core stalled
//   busy          : session in progress
//   done          : last session completed without error (level)
//   error         : last session aborted on an illegal opcode (level)
//   word_count    : words written in the current or last session
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_w_enable,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [23:0]       mem_w_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    // Instruction set opcodes
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LD  = 8'h01;
    localparam logic [7:0] OP_LDR = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_INC = 8'h05;
    localparam logic [7:0] OP_DEC = 8'h06;

    // A length byte of 0 means a full memory; bytes above the memory size
    // (only possible when ADDR_W < 8) saturate to a full memory.
    localparam int unsigned     FULL_INT   = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(FULL_INT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_OPC,
        S_ARGA,
        S_ARGB,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W:0]   target;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        opcode;
    logic [7:0]        arg_a;
    logic [7:0]        arg_b;

    logic              rx_state;
    logic              xfer;
    logic              opc_legal;
    logic [ADDR_W:0]   len_target;
    logic [ADDR_W:0]   count_inc;

    assign rx_state   = (state == S_LEN) || (state == S_OPC) ||
                        (state == S_ARGA) || (state == S_ARGB);
    assign byte_ready = rx_state;
    assign xfer       = byte_valid && rx_state;
    assign count_inc  = word_count + (ADDR_W+1)'(1);

    always_comb begin
        opc_legal = 1'b0;
        case (byte_data)
            OP_NOP, OP_LD, OP_LDR, OP_ADD, OP_SUB, OP_INC, OP_DEC: opc_legal = 1'b1;
            default: opc_legal = 1'b0;
        endcase
    end

    always_comb begin
        len_target = (ADDR_W+1)'(byte_data);
        if ((byte_data == 8'd0) || (32'(byte_data) > FULL_INT)) begin
            len_target = FULL_COUNT;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        mem_w_enable = 1'b0;
        mem_w_addr   = '0;
        mem_w_data   = '0;

        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_LEN;
            end
            S_ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
                if (start) state_next = S_LEN;
            end
            S_LEN: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (xfer) state_next = S_OPC;
            end
            S_OPC: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (xfer) state_next = opc_legal ? S_ARGA : S_ERR;
            end
            S_ARGA: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (xfer) state_next = S_ARGB;
            end
            S_ARGB: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (xfer) state_next = S_WRITE;
            end
            S_WRITE: begin
                busy         = 1'b1;
                cpu_hold     = 1'b1;
                mem_w_enable = 1'b1;
                mem_w_addr   = addr;
                mem_w_data   = {opcode, arg_a, arg_b};
                state_next   = (count_inc == target) ? S_DONE : S_OPC;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register plus the session datapath. Reset also drops any
    // partially received word, so no write can follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            target     <= '0;
            addr       <= '0;
            word_count <= '0;
            opcode     <= '0;
            arg_a      <= '0;
            arg_b      <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        word_count <= '0;
                        addr       <= '0;
                    end
                end
                S_LEN: begin
                    if (xfer) target <= len_target;
                end
                S_OPC: begin
                    if (xfer && opc_legal) opcode <= byte_data;
                end
                S_ARGA: begin
                    if (xfer) arg_a <= byte_data;
                end
                S_ARGB: begin
                    if (xfer) arg_b <= byte_data;
                end
                S_WRITE: begin
                    // Address wraps naturally at 2^ADDR_W
                    addr       <= addr + ADDR_W'(1);
                    word_count <= count_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking randomized testbench for prog_loader
module tb_prog_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_w_enable;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [23:0]       mem_w_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_w_enable (mem_w_enable),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] legal_ops [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    localparam logic [7:0] LD  = 8'h01;
    localparam logic [7:0] LDR = 8'h02;
    localparam logic [7:0] ADD = 8'h03;
    localparam logic [7:0] INC = 8'h05;

    int          cyc       = 0;
    int          last_xfer = -10;
    int          lat_err   = 0;
    int          bus_err   = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc++;

    // Write monitor: records every write, checks write latency against the
    // last accepted byte, and checks the bus is quiet between writes.
    always @(negedge clk) begin
        if (mem_w_enable) begin
            obs_q.push_back({mem_w_addr, mem_w_data});
            if (last_xfer != cyc - 1) lat_err++;
        end else if (mem_w_addr != '0 || mem_w_data != '0) begin
            bus_err++;
        end
        if (byte_valid && byte_ready) last_xfer = cyc;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [7:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: derives expected writes and the session outcome
    // directly from the byte stream.
    task automatic model(input logic [7:0] s[$], output bit err, output int cnt, output int used);
        int n;
        exp_q.delete();
        err  = 1'b0;
        cnt  = 0;
        n    = (s[0] == 8'd0) ? 256 : int'(s[0]);
        used = 1;
        for (int i = 0; i < n; i++) begin
            logic [7:0] op;
            op = s[1 + 3*i];
            used++;
            if (!is_legal(op)) begin
                err = 1'b1;
                return;
            end
            exp_q.push_back({8'(i), op, s[2 + 3*i], s[3 + 3*i]});
            used += 2;
            cnt++;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " byte_ready"},   byte_ready,   0);
        check({tag, " mem_w_enable"}, mem_w_enable, 0);
        check({tag, " cpu_hold"},     cpu_hold,     0);
        check({tag, " busy"},         busy,         0);
        check({tag, " done"},         done,         0);
        check({tag, " error"},        error,        0);
        check({tag, " mem_w_addr"},   mem_w_addr,   0);
        check({tag, " mem_w_data"},   mem_w_data,   0);
        check({tag, " word_count"},   word_count,   0);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents the first 'count' bytes of s with random idle gaps. When
    // start_in_write is set, start is pulsed in the WRITE cycle of word 0.
    task automatic feed(input string tag, input logic [7:0] s[$], input int count,
                        input int maxgap, input bit start_in_write);
        int t;
        bit got;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(maxgap, 0)) tick();
            byte_valid = 1'b1;
            byte_data  = s[i];
            t   = 0;
            got = 1'b0;
            while (!got && t < 50) begin
                @(negedge clk);
                got = byte_ready;
                tick();
                t++;
            end
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            if (!got) begin
                check({tag, " ready timeout"}, 0, 1);
                break;
            end
            if (start_in_write && i == 3) pulse_start();
        end
    endtask

    task automatic run_session(input string tag, input logic [7:0] s[$], input int maxgap,
                               input bit start_in_write);
        bit err;
        int cnt;
        int used;
        int base;
        int lat0;
        int bus0;
        int t;
        int n;
        model(s, err, cnt, used);
        base = obs_q.size();
        lat0 = lat_err;
        bus0 = bus_err;
        pulse_start();
        feed(tag, s, used, maxgap, start_in_write);
        t = 0;
        while (!(done || error) && t < 20) begin
            tick();
            t++;
        end
        repeat (2) tick();
        check({tag, " done"},       done,       !err);
        check({tag, " error"},      error,      err);
        check({tag, " cpu_hold"},   cpu_hold,   err);
        check({tag, " busy"},       busy,       0);
        check({tag, " word_count"}, word_count, cnt);
        check({tag, " num_writes"}, obs_q.size() - base, exp_q.size());
        n = (obs_q.size() - base < exp_q.size()) ? obs_q.size() - base : exp_q.size();
        for (int k = 0; k < n; k++) check({tag, " write"}, obs_q[base + k], exp_q[k]);
        check({tag, " write_latency"}, lat_err - lat0, 0);
        check({tag, " idle_bus_zero"}, bus_err - bus0, 0);
    endtask

    initial begin
        logic [7:0] s[$];
        int         base;

        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("after_reset");

        // Two-word load, no stalls
        s = '{8'h02, LDR, 8'h03, 8'h2A, ADD, 8'h03, 8'h01};
        run_session("two_word", s, 0, 1'b0);

        // Illegal opcode, then a new start clears error
        s = '{8'h01, 8'hFF};
        run_session("illegal_op", s, 0, 1'b0);
        pulse_start();
        check("restart error", error, 0);
        check("restart busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Single word with stalls between bytes
        s = '{8'h01, INC, 8'h05, 8'h00};
        run_session("gaps", s, 5, 1'b0);

        // Length byte 0 means a full 256-word memory
        s = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            s.push_back(legal_ops[$urandom_range(6, 0)]);
            s.push_back(8'($urandom));
            s.push_back(8'($urandom));
        end
        run_session("full_mem", s, 0, 1'b0);

        // start pulsed during a WRITE cycle must be ignored
        s = '{8'h03, LD, 8'h10, 8'h20, ADD, 8'h30, 8'h40, INC, 8'h50, 8'h60};
        run_session("start_in_write", s, 2, 1'b1);

        // Randomized sessions, some ending on an illegal opcode
        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(12, 1);
            s.delete();
            s.push_back(8'(len));
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(7, 0) == 0) s.push_back(8'($urandom_range(255, 7)));
                else                           s.push_back(legal_ops[$urandom_range(6, 0)]);
                s.push_back(8'($urandom));
                s.push_back(8'($urandom));
            end
            run_session($sformatf("random%0d", r), s, $urandom_range(3, 0), 1'b0);
        end

        // Reset after arg_a of word 1 in a 3-word load
        s = '{8'h03, LD, 8'h11, 8'h22, ADD, 8'h33, 8'h44, INC, 8'h55, 8'h66};
        base = obs_q.size();
        pulse_start();
        feed("reset_mid", s, 6, 1, 1'b0);
        rst = 1'b1;
        tick();
        check_idle("reset_mid during");
        rst = 1'b0;
        repeat (5) tick();
        check_idle("reset_mid after");
        check("reset_mid num_writes", obs_q.size() - base, 1);
        if (obs_q.size() > base) check("reset_mid word0", obs_q[base], {8'h00, LD, 8'h11, 8'h22});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, meaning program-memory address width (max 2^ADDR_W words).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle pulse; begins a load session.
REQ-005 byte_valid  input  1  source presents byte_data this cycle.
REQ-006 byte_data  input  8  stream byte.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_w_enable  output  1  program-memory write strobe, one cycle per word.
REQ-009 mem_w_addr  output  ADDR_W  program-memory write address.
REQ-010 mem_w_data  output  24  instruction word: [23:16] opcode, [15:8] arg_a, [7:0] arg_b.
REQ-011 cpu_hold  output  1  holds the CPU core stalled while 1.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  last session completed without error; level.
REQ-014 error  output  1  last session aborted on an illegal opcode; level.
REQ-015 word_count  output  ADDR_W+1  number of words written in the current or last session.

Function
REQ-016 Handshake: a byte transfers only in a cycle where byte_valid and byte_ready are both 1; byte_data is ignored otherwise.
REQ-017 States: IDLE, LEN, OPC, ARGA, ARGB, WRITE, DONE, ERR.
REQ-018 IDLE/DONE/ERR: start=1 -> LEN; word_count, write address and done/error cleared on that edge.
REQ-019 start is ignored in LEN, OPC, ARGA, ARGB, WRITE.
REQ-020 LEN: accepted byte L sets target N = L, with L=0 meaning 2^ADDR_W; L greater than 2^ADDR_W is impossible for ADDR_W=8 and is saturated to 2^ADDR_W for smaller ADDR_W; -> OPC.
REQ-021 OPC: accepted byte is checked against the opcode set in global params (NOP, LD, LDR, ADD, SUB, INC, DEC); legal -> latch, -> ARGA; illegal -> ERR, no write.
REQ-022 ARGA: accepted byte latched as arg_a -> ARGB; ARGB: accepted byte latched as arg_b -> WRITE.
REQ-023 byte_ready = 1 exactly in LEN, OPC, ARGA, ARGB; 0 in all other states.
REQ-024 WRITE (one cycle): mem_w_enable=1, mem_w_addr = current address, mem_w_data = {opcode, arg_a, arg_b}; on exit address +1 and word_count +1.
REQ-025 Write latency: mem_w_enable asserts in the cycle immediately after the arg_b transfer.
REQ-026 WRITE exit: if word_count+1 == N -> DONE, else -> OPC.
REQ-027 Address wraps modulo 2^ADDR_W; a full 2^ADDR_W session ends with address back at 0 and word_count = 2^ADDR_W.
REQ-028 mem_w_addr and mem_w_data hold 0 whenever mem_w_enable = 0.
REQ-029 busy = 1 in LEN, OPC, ARGA, ARGB, WRITE.
REQ-030 cpu_hold = 1 in LEN, OPC, ARGA, ARGB, WRITE, ERR; 0 in IDLE and DONE.
REQ-031 done = 1 only in DONE; error = 1 only in ERR.
REQ-032 byte_valid stalls of any length in any receiving state leave all state unchanged.

Reset
REQ-033 rst=1 at a clock edge forces IDLE from any state, including mid-session and mid-WRITE, taking priority over start and byte transfers.
REQ-034 During and after reset: byte_ready, mem_w_enable, cpu_hold, busy, done, error = 0; mem_w_addr, mem_w_data, word_count = 0.
REQ-035 A word partially received when reset hits is discarded; no write is issued for it.

Verification
REQ-036 start; bytes 02, LDR,03,2A, ADD,03,01 with valid held high -> writes {LDR,03,2A}@0 and {ADD,03,01}@1, each one cycle after the arg_b byte; DONE, word_count=2, cpu_hold drops.
REQ-037 start; length 01; opcode byte 0xFF (not in set) -> ERR, error=1, cpu_hold=1, no mem_w_enable; a new start clears error.
REQ-038 start; length 01; random byte_valid gaps of 0-5 cycles -> single write {INC,05,00}@0 is identical to the no-gap case.
REQ-039 start; length 00 (ADDR_W=8) -> 256 writes at addresses 0..255, word_count=256, done=1.
REQ-040 rst asserted after the arg_a byte of word 1 in a 3-word load -> IDLE next cycle, all outputs 0, word 1 never written; start pulsed during WRITE -> ignored.
